// File: rtl/alu_exec_unit.sv
// rtl/alu_exec_unit.sv - ALU execution stage: 1-cycle ADD/XOR/AND, iterative SRA with valid/ready handshake.
// Define ALU_FAST_SHIFT_EN to compute SRA in one cycle instead of one bit per cycle.
module alu_exec_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       ALUOp,
   input  logic [WIDTH-1:0] src_a,
   input  logic [WIDTH-1:0] src_b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             busy
);
   localparam int SHAMT_W = $clog2(WIDTH);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t state, state_nxt;

   logic [SHAMT_W-1:0] shamt;
   logic [WIDTH-1:0]   quick_res;
   logic               long_shift;
   logic               accept;

   assign shamt     = src_b[SHAMT_W-1:0];
   assign accept    = (state == IDLE) && in_valid;
   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);
   assign busy      = (state != IDLE);

   // Result of every op that completes on the accept edge.
   always_comb begin
      quick_res = '0;
      case (ALUOp)
         2'b00:   quick_res = src_a + src_b;
         2'b01:   quick_res = src_a ^ src_b;
         2'b10:   quick_res = src_a & src_b;
`ifdef ALU_FAST_SHIFT_EN
         default: quick_res = $unsigned($signed(src_a) >>> shamt);
`else
         default: quick_res = src_a;
`endif
      endcase
   end

`ifdef ALU_FAST_SHIFT_EN
   assign long_shift = 1'b0;
`else
   logic [WIDTH-1:0]   acc;
   logic [SHAMT_W-1:0] cnt;
   logic [WIDTH-1:0]   shifted;

   assign long_shift = (ALUOp == 2'b11) && (shamt != '0);
   assign shifted    = {acc[WIDTH-1], acc[WIDTH-1:1]};

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         acc <= '0;
         cnt <= '0;
      end else if (accept && long_shift) begin
         acc <= src_a;
         cnt <= shamt;
      end else if (state == SHIFT) begin
         acc <= shifted;
         cnt <= cnt - SHAMT_W'(1);
      end
   end
`endif

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (in_valid) state_nxt = long_shift ? SHIFT : DONE;
`ifndef ALU_FAST_SHIFT_EN
         SHIFT:   if (cnt == SHAMT_W'(1)) state_nxt = DONE;
`endif
         DONE:    if (out_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // result/zero only move on accept or on the final shift step, so DONE holds them.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         result <= '0;
         zero   <= 1'b0;
      end else if (accept && !long_shift) begin
         result <= quick_res;
         zero   <= (quick_res == '0);
      end
`ifndef ALU_FAST_SHIFT_EN
      else if (state == SHIFT && cnt == SHAMT_W'(1)) begin
         result <= shifted;
         zero   <= (shifted == '0);
      end
`endif
   end
endmodule

// File: tb/tb_alu_exec_unit.sv
// tb/tb_alu_exec_unit.sv - self-checking bench for alu_exec_unit against a behavioural model.
module tb_alu_exec_unit;
   localparam int W = 32;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         in_valid = 1'b0;
   logic         out_ready = 1'b0;
   logic [1:0]   alu_op = 2'b00;
   logic [W-1:0] src_a = '0;
   logic [W-1:0] src_b = '0;
   logic         in_ready, out_valid, zero, busy;
   logic [W-1:0] result;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   alu_exec_unit #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .ALUOp(alu_op), .src_a(src_a), .src_b(src_b), .out_valid(out_valid),
      .out_ready(out_ready), .result(result), .zero(zero), .busy(busy)
   );

   task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [W-1:0] ref_result(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      logic [W:0]   sum;
      logic [W-1:0] fill;
      int           k;
      k = int'(b % W);
      case (op)
         2'd0: begin sum = {1'b0, a} + {1'b0, b}; return sum[W-1:0]; end
         2'd1: return a ^ b;
         2'd2: return a & b;
         default: begin
            fill = a[W-1] ? ~({W{1'b1}} >> k) : '0;
            return (a >> k) | fill;
         end
      endcase
   endfunction

   function automatic int ref_latency(input logic [1:0] op, input logic [W-1:0] b);
`ifdef ALU_FAST_SHIFT_EN
      return 1;
`else
      if (op == 2'd3 && (b % W) != 0) return int'(b % W) + 1;
      return 1;
`endif
   endfunction

   // Starts and ends on a falling edge with the unit idle.
   task automatic run_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input int hold);
      logic [W-1:0] exp_r;
      int           exp_lat;
      int           n;
      exp_r   = ref_result(op, a, b);
      exp_lat = ref_latency(op, b);
      check("in_ready_idle", W'(in_ready), W'(1));
      alu_op = op; src_a = a; src_b = b; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0; alu_op = 2'($urandom); src_a = $urandom; src_b = $urandom;
      n = 0;
      do begin
         @(negedge clk); n++;
         if (!out_valid) check("in_ready_while_busy", W'(in_ready), W'(0));
      end while (!out_valid && n < 40);
      check("latency", W'(n), W'(exp_lat));
      check("result", result, exp_r);
      check("zero", W'(zero), W'(exp_r == '0));
      check("busy_done", W'(busy), W'(1));
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         check("hold_valid", W'(out_valid), W'(1));
         check("hold_result", result, exp_r);
         check("hold_in_ready", W'(in_ready), W'(0));
      end
      out_ready = 1'b1;
      in_valid = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      in_valid = 1'b0;
      check("release_valid", W'(out_valid), W'(0));
      check("release_no_accept", W'(busy), W'(0));
   endtask

   initial begin
      logic [1:0]   r_op;
      logic [W-1:0] r_a, r_b;

      repeat (2) @(negedge clk);
      check("rst_out_valid", W'(out_valid), W'(0));
      check("rst_in_ready", W'(in_ready), W'(1));
      check("rst_busy", W'(busy), W'(0));
      check("rst_result", result, W'(0));
      check("rst_zero", W'(zero), W'(0));

      // Request during reset is dropped.
      in_valid = 1'b1; alu_op = 2'd0; src_a = 32'd1; src_b = 32'd1;
      @(negedge clk);
      in_valid = 1'b0;
      check("rst_wins_busy", W'(busy), W'(0));
      rst_n = 1'b1;
      @(negedge clk);
      check("rst_wins_valid", W'(out_valid), W'(0));

      run_op(2'd0, 32'd5, 32'd7, 0);
      run_op(2'd0, 32'hFFFF_FFFF, 32'd1, 0);
      run_op(2'd1, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 0);
      run_op(2'd2, 32'h0000_F0F0, 32'h0000_FF00, 0);
      run_op(2'd3, 32'h8000_0000, 32'd4, 0);
      run_op(2'd3, 32'h8000_0002, 32'h21, 0);
      run_op(2'd3, 32'h9234_5678, 32'd0, 0);
      run_op(2'd3, 32'h7FFF_FFFF, 32'd31, 0);
      run_op(2'd3, 32'h8000_0000, 32'd31, 0);
      run_op(2'd0, 32'h1234_0000, 32'h0000_5678, 3);

      // Abort an in-flight shift.
      alu_op = 2'd3; src_a = 32'hC000_0000; src_b = 32'd20; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (4) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      check("abort_valid", W'(out_valid), W'(0));
      check("abort_in_ready", W'(in_ready), W'(1));
      check("abort_result", result, W'(0));
      for (int i = 0; i < 25; i++) begin
         @(negedge clk);
         if (out_valid) check("abort_no_emit", W'(out_valid), W'(0));
      end
      run_op(2'd0, 32'd100, 32'd23, 0);

      for (int i = 0; i < 40; i++) begin
         r_op = 2'($urandom);
         r_a  = $urandom;
         r_b  = (i % 3 == 0) ? 32'($urandom_range(0, 31)) : $urandom;
         if (i % 7 == 0) r_b = r_a;
         run_op(r_op, r_a, r_b, int'($urandom_range(0, 2)));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
